// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with a valid/ready handshake, a two-entry skid buffer and flush.
// An invalid output always presents the NOP bundle; a saturating counter tracks bubble cycles.
module id_ex_pipe #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int ALUOP_W    = 8,
  parameter int ALUSEL_W   = 3,
  parameter int NOP_ALUOP  = 0,
  parameter int NOP_ALUSEL = 0,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [ADDR_W-1:0]   id_wd,
  input  logic                id_wreg,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [ADDR_W-1:0]   ex_wd,
  output logic                ex_wreg,
  output logic [CNT_W-1:0]    bubble_cnt
);

  localparam int BW = ALUOP_W + ALUSEL_W + 2 * DATA_W + ADDR_W + 1;
  localparam logic [ALUOP_W-1:0]  NOP_OP  = ALUOP_W'(NOP_ALUOP);
  localparam logic [ALUSEL_W-1:0] NOP_SEL = ALUSEL_W'(NOP_ALUSEL);
  localparam logic [BW-1:0] NOP_BUNDLE =
    {NOP_OP, NOP_SEL, {DATA_W{1'b0}}, {DATA_W{1'b0}}, {ADDR_W{1'b0}}, 1'b0};

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   main_q, main_d;
  logic [BW-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [BW-1:0]   in_bundle;
  logic            in_x, out_x;

  assign in_bundle = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};
  assign in_x      = id_valid & id_ready;
  assign out_x     = ex_valid & ex_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_q       <= NOP_BUNDLE;
      skid_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Next state and data-path loads; flush wins over any handshake this cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_BUNDLE;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_x) begin
            state_d = ONE;
            main_d  = in_bundle;
          end
        end
        ONE: begin
          if (in_x && out_x) begin
            main_d = in_bundle;
          end else if (in_x) begin
            state_d = TWO;
            skid_d  = in_bundle;
          end else if (out_x) begin
            state_d = EMPTY;
            main_d  = NOP_BUNDLE;
          end
        end
        TWO: begin
          if (out_x) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_BUNDLE;
        end
      endcase
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (state_q == EMPTY && bubble_cnt_q != {CNT_W{1'b1}})
      bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  // Handshake outputs depend on registered state only.
  always_comb begin
    id_ready = (state_q != TWO);
    ex_valid = (state_q != EMPTY);
  end

  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg} = main_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule
